// File: rtl/dbg_trace_pkg.sv
// Shared types and state encodings for the retire-trace recorder.
// Optional macro DBG_TRACE_TIMESTAMP_EN adds a 32-bit timestamp to every trace entry.
package dbg_trace_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef DBG_TRACE_TIMESTAMP_EN
        logic [31:0] ts;
`endif
    } trace_entry_t;

endpackage

// File: rtl/dbg_trace_ram.sv
// Trace storage: DEPTH entries, one write and one registered read port, no reset.
// Entry width follows trace_entry_t, so DBG_TRACE_TIMESTAMP_EN widens it automatically.
module dbg_trace_ram
    import dbg_trace_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [PTR_BITS-1:0] wr_addr_i,
    input  trace_entry_t        wr_data_i,
    input  logic [PTR_BITS-1:0] rd_addr_i,
    output trace_entry_t        rd_data_o
);

    trace_entry_t mem_q [DEPTH];

    // Read samples the array before this edge's write lands, giving old data on a collision.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/dbg_trace_recorder.sv
// Retire-trace recorder: PC-match triggering, post-trigger window, wrap tracking and telemetry counters.
// Define DBG_TRACE_TIMESTAMP_EN to store mcycle[31:0] per entry and expose rd_ts_o.
module dbg_trace_recorder
    import dbg_trace_pkg::*;
#(
    parameter int  DEPTH    = 64,
    parameter int  NUM_TRIG = 2,
    parameter int  CNT_W    = 64,
    localparam int PTR_BITS = $clog2(DEPTH),
    localparam int TIDX_W   = $clog2(NUM_TRIG) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  retire_i,
    input  logic [31:0]           retire_pc_i,
    input  logic [31:0]           retire_instr_i,
    input  logic                  stall_i,
    input  logic                  arm_i,
    input  logic [NUM_TRIG*32-1:0] trig_pc_i,
    input  logic [NUM_TRIG-1:0]   trig_en_i,
    input  logic [PTR_BITS-1:0]   post_count_i,
    input  logic [PTR_BITS-1:0]   rd_addr_i,
    output logic [31:0]           rd_pc_o,
    output logic [31:0]           rd_instr_o,
`ifdef DBG_TRACE_TIMESTAMP_EN
    output logic [31:0]           rd_ts_o,
`endif
    output logic [1:0]            state_o,
    output logic                  triggered_o,
    output logic [TIDX_W-1:0]     trig_idx_o,
    output logic [PTR_BITS-1:0]   wr_ptr_o,
    output logic                  wrapped_o,
    output logic [CNT_W-1:0]      mcycle_o,
    output logic [CNT_W-1:0]      minstret_o,
    output logic [CNT_W-1:0]      stall_o
);

    logic [1:0]          state_q, state_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] remain_q, remain_d;
    logic                wrapped_q, wrapped_d;
    logic                triggered_q, triggered_d;
    logic [TIDX_W-1:0]   trig_idx_q, trig_idx_d;
    logic [CNT_W-1:0]    mcycle_q, minstret_q, stall_q;
    logic                rd_valid_q;
    logic                hit, wr_en;
    logic [TIDX_W-1:0]   hit_idx;
    trace_entry_t        wr_entry, rd_entry;

    // Scan from the top so the lowest matching comparator is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_TRIG - 1; k >= 0; k--) begin
            if (trig_en_i[k] && (retire_pc_i == trig_pc_i[32*k +: 32])) begin
                hit     = 1'b1;
                hit_idx = TIDX_W'(k);
            end
        end
    end

    assign wr_en = retire_i && !arm_i && ((state_q == ST_ARMED) || (state_q == ST_POST));

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = retire_pc_i;
        wr_entry.instr = retire_instr_i;
`ifdef DBG_TRACE_TIMESTAMP_EN
        wr_entry.ts    = mcycle_q[31:0];
`endif
    end

    // post_count_i is PTR_BITS wide, so it can never exceed DEPTH-1 and the trigger entry survives.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        remain_d    = remain_q;
        wrapped_d   = wrapped_q;
        triggered_d = triggered_q;
        trig_idx_d  = trig_idx_q;
        if (arm_i) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            wrapped_d   = 1'b0;
            triggered_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            if (wr_ptr_q == PTR_BITS'(DEPTH - 1)) begin
                wrapped_d = 1'b1;
            end
            if ((state_q == ST_ARMED) && hit) begin
                triggered_d = 1'b1;
                trig_idx_d  = hit_idx;
                if (post_count_i == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_POST;
                    remain_d = post_count_i;
                end
            end else if (state_q == ST_POST) begin
                remain_d = remain_q - PTR_BITS'(1);
                if (remain_q == PTR_BITS'(1)) begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            remain_q    <= '0;
            wrapped_q   <= 1'b0;
            triggered_q <= 1'b0;
            trig_idx_q  <= '0;
            mcycle_q    <= '0;
            minstret_q  <= '0;
            stall_q     <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            remain_q    <= remain_d;
            wrapped_q   <= wrapped_d;
            triggered_q <= triggered_d;
            trig_idx_q  <= trig_idx_d;
            mcycle_q    <= mcycle_q + CNT_W'(1);
            minstret_q  <= minstret_q + CNT_W'(retire_i);
            stall_q     <= stall_q + CNT_W'(stall_i);
            rd_valid_q  <= 1'b1;
        end
    end

    dbg_trace_ram #(
        .DEPTH    (DEPTH),
        .PTR_BITS (PTR_BITS)
    ) u_ram (
        .clk_i     (clk_i),
        .we_i      (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_entry)
    );

    // The RAM has no reset, so read data is masked until the first post-reset read completes.
    assign rd_pc_o     = rd_valid_q ? rd_entry.pc    : 32'd0;
    assign rd_instr_o  = rd_valid_q ? rd_entry.instr : 32'd0;
`ifdef DBG_TRACE_TIMESTAMP_EN
    assign rd_ts_o     = rd_valid_q ? rd_entry.ts    : 32'd0;
`endif
    assign state_o     = state_q;
    assign triggered_o = triggered_q;
    assign trig_idx_o  = trig_idx_q;
    assign wr_ptr_o    = wr_ptr_q;
    assign wrapped_o   = wrapped_q;
    assign mcycle_o    = mcycle_q;
    assign minstret_o  = minstret_q;
    assign stall_o     = stall_q;

endmodule

// File: tb/tb_dbg_trace_recorder.sv
// Directed self-checking bench for dbg_trace_recorder (DEPTH=64, NUM_TRIG=2).
// Build with DBG_TRACE_TIMESTAMP_EN defined to also exercise rd_ts_o.
module tb_dbg_trace_recorder;

    logic        clk;
    logic        rst;
    logic        retire;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic        stall;
    logic        arm;
    logic [63:0] trig_pc;
    logic [1:0]  trig_en;
    logic [5:0]  post_count;
    logic [5:0]  rd_addr;
    logic [31:0] rd_pc, rd_instr;
`ifdef DBG_TRACE_TIMESTAMP_EN
    logic [31:0] rd_ts;
`endif
    logic [1:0]  state;
    logic        triggered;
    logic [1:0]  trig_idx;
    logic [5:0]  wr_ptr;
    logic        wrapped;
    logic [63:0] mcycle, minstret, stall_cnt;

    int checks = 0;
    int errors = 0;

    dbg_trace_recorder #(.DEPTH(64), .NUM_TRIG(2), .CNT_W(64)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .retire_i       (retire),
        .retire_pc_i    (retire_pc),
        .retire_instr_i (retire_instr),
        .stall_i        (stall),
        .arm_i          (arm),
        .trig_pc_i      (trig_pc),
        .trig_en_i      (trig_en),
        .post_count_i   (post_count),
        .rd_addr_i      (rd_addr),
        .rd_pc_o        (rd_pc),
        .rd_instr_o     (rd_instr),
`ifdef DBG_TRACE_TIMESTAMP_EN
        .rd_ts_o        (rd_ts),
`endif
        .state_o        (state),
        .triggered_o    (triggered),
        .trig_idx_o     (trig_idx),
        .wr_ptr_o       (wr_ptr),
        .wrapped_o      (wrapped),
        .mcycle_o       (mcycle),
        .minstret_o     (minstret),
        .stall_o        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_retire(input logic [31:0] pc);
        retire       = 1'b1;
        retire_pc    = pc;
        retire_instr = 32'hA5A5_0000 | pc;
        tick();
        retire = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", state); end
        checks++;
        if (mcycle !== 64'd0 || minstret !== 64'd0 || stall_cnt !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_counters got %0d/%0d/%0d want 0/0/0", mcycle, minstret, stall_cnt);
        end
        checks++;
        if (wr_ptr !== 6'd0 || wrapped !== 1'b0 || triggered !== 1'b0 || trig_idx !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_flags got ptr=%0d wrap=%0b trig=%0b idx=%0d want 0", wr_ptr, wrapped, triggered, trig_idx);
        end
        checks++;
        if (rd_pc !== 32'd0 || rd_instr !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_rd got %h/%h want 0/0", rd_pc, rd_instr);
        end
    endtask

    task automatic test_counters();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            retire    = (i < 40);
            retire_pc = 32'h0000_0800 + 32'(i * 4);
            stall     = (i >= 50) && (i < 57);
            tick();
        end
        retire = 1'b0;
        stall  = 1'b0;
        checks++;
        if (mcycle !== 64'd100) begin errors++; $display("[TB] FAIL mcycle got %0d want 100", mcycle); end
        checks++;
        if (minstret !== 64'd40) begin errors++; $display("[TB] FAIL minstret got %0d want 40", minstret); end
        checks++;
        if (stall_cnt !== 64'd7) begin errors++; $display("[TB] FAIL stall_cnt got %0d want 7", stall_cnt); end
        checks++;
        if (state !== 2'd0 || wr_ptr !== 6'd0) begin
            errors++; $display("[TB] FAIL idle_no_write got state=%0d ptr=%0d want 0/0", state, wr_ptr);
        end
    endtask

    task automatic test_wrap();
        trig_en = 2'b00;
        do_arm();
        checks++;
        if (state !== 2'd1 || wr_ptr !== 6'd0) begin
            errors++; $display("[TB] FAIL arm_state got state=%0d ptr=%0d want 1/0", state, wr_ptr);
        end
        for (int i = 0; i < 70; i++) begin
            do_retire(32'h0000_1000 + 32'(i * 4));
        end
        checks++;
        if (wrapped !== 1'b1 || wr_ptr !== 6'd6) begin
            errors++; $display("[TB] FAIL wrap got wrapped=%0b ptr=%0d want 1/6", wrapped, wr_ptr);
        end
        rd_addr = 6'd6;
        tick();
        checks++;
        if (rd_pc !== 32'h0000_1018 || rd_instr !== 32'hA5A5_1018) begin
            errors++; $display("[TB] FAIL wrap_rd6 got %h/%h want 00001018/a5a51018", rd_pc, rd_instr);
        end
        rd_addr = 6'd0;
        tick();
        checks++;
        if (rd_pc !== 32'h0000_1100) begin errors++; $display("[TB] FAIL wrap_rd0 got %h want 00001100", rd_pc); end
    endtask

    task automatic test_trigger_post();
        logic [31:0] pcs [7];
        logic [1:0]  exp_state [7];
        logic [5:0]  exp_ptr [7];
        pcs       = '{32'hF8, 32'hFC, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
        exp_state = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
        exp_ptr   = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd6};
        trig_pc    = {32'h0, 32'h100};
        trig_en    = 2'b01;
        post_count = 6'd3;
        do_arm();
        for (int i = 0; i < 7; i++) begin
            do_retire(pcs[i]);
            checks++;
            if (state !== exp_state[i] || wr_ptr !== exp_ptr[i]) begin
                errors++; $display("[TB] FAIL post_step%0d got state=%0d ptr=%0d want %0d/%0d", i, state, wr_ptr, exp_state[i], exp_ptr[i]);
            end
        end
        checks++;
        if (triggered !== 1'b1 || trig_idx !== 2'd0 || wrapped !== 1'b0) begin
            errors++; $display("[TB] FAIL post_flags got trig=%0b idx=%0d wrap=%0b want 1/0/0", triggered, trig_idx, wrapped);
        end
        rd_addr = 6'd2;
        tick();
        checks++;
        if (rd_pc !== 32'h100) begin errors++; $display("[TB] FAIL post_rd2 got %h want 00000100", rd_pc); end
        rd_addr = 6'd6;
        tick();
        checks++;
        if (rd_pc !== 32'h0000_1018) begin errors++; $display("[TB] FAIL post_rd6 got %h want 00001018", rd_pc); end
    endtask

    task automatic test_dual_trigger();
        trig_pc    = {32'h200, 32'h200};
        trig_en    = 2'b11;
        post_count = 6'd0;
        do_arm();
        do_retire(32'h1FC);
        do_retire(32'h200);
        checks++;
        if (state !== 2'd3 || trig_idx !== 2'd0 || wr_ptr !== 6'd2 || triggered !== 1'b1) begin
            errors++; $display("[TB] FAIL dual got state=%0d idx=%0d ptr=%0d trig=%0b want 3/0/2/1", state, trig_idx, wr_ptr, triggered);
        end
        do_retire(32'h204);
        checks++;
        if (wr_ptr !== 6'd2) begin errors++; $display("[TB] FAIL done_hold got ptr=%0d want 2", wr_ptr); end
        trig_pc = {32'h300, 32'h300};
        trig_en = 2'b10;
        do_arm();
        do_retire(32'h300);
        checks++;
        if (state !== 2'd3 || trig_idx !== 2'd1 || wr_ptr !== 6'd1) begin
            errors++; $display("[TB] FAIL comp1 got state=%0d idx=%0d ptr=%0d want 3/1/1", state, trig_idx, wr_ptr);
        end
    endtask

    task automatic test_arm_retire();
        arm          = 1'b1;
        retire       = 1'b1;
        retire_pc    = 32'h400;
        retire_instr = 32'hA5A5_0400;
        tick();
        arm    = 1'b0;
        retire = 1'b0;
        checks++;
        if (wr_ptr !== 6'd0 || state !== 2'd1 || triggered !== 1'b0) begin
            errors++; $display("[TB] FAIL arm_retire got ptr=%0d state=%0d trig=%0b want 0/1/0", wr_ptr, state, triggered);
        end
        rd_addr = 6'd0;
        tick();
        checks++;
        if (rd_pc !== 32'h300) begin errors++; $display("[TB] FAIL arm_retire_rd got %h want 00000300", rd_pc); end
    endtask

    task automatic test_reset_in_post();
        trig_pc    = {32'h0, 32'h500};
        trig_en    = 2'b01;
        post_count = 6'd5;
        do_retire(32'h4FC);
        do_retire(32'h500);
        checks++;
        if (state !== 2'd2) begin errors++; $display("[TB] FAIL pre_reset_state got %0d want 2", state); end
        rst = 1'b1;
        tick();
        checks++;
        if (state !== 2'd0 || wr_ptr !== 6'd0 || triggered !== 1'b0 || rd_pc !== 32'd0) begin
            errors++; $display("[TB] FAIL post_reset got state=%0d ptr=%0d trig=%0b rd=%h want 0", state, wr_ptr, triggered, rd_pc);
        end
        checks++;
        if (mcycle !== 64'd0 || minstret !== 64'd0 || stall_cnt !== 64'd0) begin
            errors++; $display("[TB] FAIL post_reset_cnt got %0d/%0d/%0d want 0/0/0", mcycle, minstret, stall_cnt);
        end
        rst = 1'b0;
    endtask

`ifdef DBG_TRACE_TIMESTAMP_EN
    task automatic test_timestamp();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        trig_en = 2'b00;
        do_arm();
        repeat (49) tick();
        checks++;
        if (mcycle !== 64'd50) begin errors++; $display("[TB] FAIL ts_mcycle got %0d want 50", mcycle); end
        do_retire(32'h600);
        rd_addr = 6'd0;
        tick();
        checks++;
        if (rd_ts !== 32'd50 || rd_pc !== 32'h600) begin
            errors++; $display("[TB] FAIL ts_rd got ts=%0d pc=%h want 50/00000600", rd_ts, rd_pc);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        retire       = 1'b0;
        retire_pc    = '0;
        retire_instr = '0;
        stall        = 1'b0;
        arm          = 1'b0;
        trig_pc      = '0;
        trig_en      = '0;
        post_count   = '0;
        rd_addr      = '0;
        test_reset();
        test_counters();
        test_wrap();
        test_trigger_post();
        test_dual_trigger();
        test_arm_retire();
        test_reset_in_post();
`ifdef DBG_TRACE_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
